// File: rtl/zoom_sequencer_if.sv
// ---------------------------------------------------------------------------
// zoom_sequencer_if
// Bundles the command, source-RAM and frame-buffer signals of the zoom
// sequencer. The clock and reset stay as plain ports on the module.
//
// Handshakes:
//   command : a command is taken on a rising clock edge where
//             cmd_valid & cmd_ready. cmd_ready is high only while the
//             sequencer is idle.
//   fb write: a write is taken on a rising clock edge where
//             fb_we & fb_ready. fb_we, fb_addr and fb_data stay stable
//             until that edge.
//
// Signals (direction seen from the sequencer, modport master):
//   cmd_valid  in   command request
//   cmd_ready  out  sequencer idle, command can be taken
//   cmd_zoom   in   0 = /4 nearest, 1 = /2 average, 2 = copy, 3..7 illegal
//   abort      in   cancel the running job
//   rom_addr   out  registered source read address
//   rom_data   in   source pixel, valid the cycle after rom_addr
//   fb_we      out  frame-buffer write request
//   fb_addr    out  frame-buffer write address
//   fb_data    out  frame-buffer write pixel
//   fb_ready   in   frame buffer takes the write this cycle
//   busy       out  job in progress
//   done       out  one-cycle job-complete pulse
//   err        out  one-cycle illegal-zoom pulse
// The slave modport is the environment side (RAM, frame buffer, host).
// ---------------------------------------------------------------------------
interface zoom_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_zoom;
    logic        abort;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_ready;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  cmd_valid, cmd_zoom, abort, rom_data, fb_ready,
        output cmd_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_zoom, abort, rom_data, fb_ready,
        input  cmd_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done, err
    );
endinterface

// File: rtl/zoom_sequencer.sv
// ---------------------------------------------------------------------------
// zoom_sequencer
// Walks a 160x120 source image held in a single-port synchronous RAM. For
// each output pixel it fetches one source pixel (nearest / copy) or a 2x2
// block (average). It then writes the result linearly into the shared frame
// buffer under fb_ready backpressure.
//
// Ports:
//   clk        single clock, all logic on posedge
//   reset_n    asynchronous active-low reset
//   bus        zoom_sequencer_if.master (command, source RAM, frame buffer,
//              status)
//   state_dbg  current FSM state (IDLE=0, FETCH=1, WRITE=2, FINISH=3)
//
// Parameters: IMG_WIDTH_IN, IMG_HEIGHT_IN (source geometry), FB_BASE
// (frame-buffer address of output pixel 0).
//
// Build option: define ZOOM_ROUND_EN to round the 2x2 average,
// (sum + 2) >> 2. Without it the average truncates, sum >> 2.
// ---------------------------------------------------------------------------
module zoom_sequencer #(
    parameter int          IMG_WIDTH_IN  = 160,
    parameter int          IMG_HEIGHT_IN = 120,
    parameter logic [18:0] FB_BASE       = 19'd0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    zoom_sequencer_if.master        bus,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [14:0] ROW_STRIDE = 15'(IMG_WIDTH_IN);
    localparam logic [7:0]  W_FULL     = 8'(IMG_WIDTH_IN);
    localparam logic [6:0]  H_FULL     = 7'(IMG_HEIGHT_IN);

    state_t      state_q, state_d;

    logic [2:0]  zoom_q;
    logic [7:0]  x_out_q;
    logic [6:0]  y_out_q;
    logic [2:0]  k_q;          // fetch phase within the current pixel
    logic [14:0] write_ptr_q;
    logic [9:0]  sum_q;        // running sum of captured pixels
    logic [7:0]  result_q;
    logic [14:0] rom_addr_q;
    logic        err_q;

    logic [1:0]  shift;
    logic [7:0]  out_w;
    logic [6:0]  out_h;
    logic [14:0] n_pix;
    logic        is_avg;
    logic        fetch_last;
    logic        wr_last;
    logic        x_wrap;
    logic [7:0]  x_next;
    logic [6:0]  y_next;
    logic [14:0] base_addr;
    logic [14:0] next_base;
    logic [9:0]  sum_full;
    logic [7:0]  avg_result;
    logic        cmd_legal;

    // Source address of the top-left pixel for output (x, y) at shift s.
    function automatic logic [14:0] src_addr(input logic [7:0] x,
                                             input logic [6:0] y,
                                             input logic [1:0] s);
        logic [14:0] xi;
        logic [14:0] yi;
        xi = {7'd0, x} << s;
        yi = {8'd0, y} << s;
        return yi * ROW_STRIDE + xi;
    endfunction

    // ---------------- geometry and datapath helpers ----------------
    always_comb begin
        shift      = 2'd2 - zoom_q[1:0];
        out_w      = W_FULL >> shift;
        out_h      = H_FULL >> shift;
        n_pix      = {7'd0, out_w} * {8'd0, out_h};
        is_avg     = (zoom_q == 3'd1);
        // Average needs four captures (k = 1..4), nearest needs one (k = 1).
        fetch_last = is_avg ? (k_q == 3'd4) : (k_q == 3'd1);
        wr_last    = (write_ptr_q == n_pix - 15'd1);
        x_wrap     = (x_out_q == out_w - 8'd1);
        x_next     = x_wrap ? 8'd0 : x_out_q + 8'd1;
        y_next     = x_wrap ? y_out_q + 7'd1 : y_out_q;
        base_addr  = src_addr(x_out_q, y_out_q, shift);
        next_base  = src_addr(x_next, y_next, shift);
        cmd_legal  = (bus.cmd_zoom <= 3'd2);
        sum_full   = sum_q + {2'b00, bus.rom_data};
`ifdef ZOOM_ROUND_EN
        avg_result = 8'((sum_full + 10'd2) >> 2);
`else
        avg_result = sum_full[9:2];
`endif
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_legal) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (fetch_last) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.fb_ready) begin
                    state_d = wr_last ? FINISH : FETCH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort wins over everything except IDLE, where it is ignored.
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // ---------------- counters, addresses, capture ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zoom_q      <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            k_q         <= '0;
            write_ptr_q <= '0;
            sum_q       <= '0;
            result_q    <= '0;
            rom_addr_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        x_out_q     <= '0;
                        y_out_q     <= '0;
                        k_q         <= '0;
                        write_ptr_q <= '0;
                        sum_q       <= '0;
                        if (cmd_legal) begin
                            zoom_q     <= bus.cmd_zoom;
                            // Output (0,0) always starts at source address 0.
                            rom_addr_q <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    k_q <= k_q + 3'd1;
                    // p0 was issued on entry; p1..p3 follow one per cycle.
                    if (is_avg) begin
                        case (k_q)
                            3'd0:    rom_addr_q <= base_addr + 15'd1;
                            3'd1:    rom_addr_q <= base_addr + ROW_STRIDE;
                            3'd2:    rom_addr_q <= base_addr + ROW_STRIDE + 15'd1;
                            default: rom_addr_q <= rom_addr_q;
                        endcase
                    end
                    // rom_data of the address issued in phase k-1 arrives in phase k.
                    if (k_q != 3'd0) begin
                        sum_q <= sum_full;
                    end
                    if (fetch_last) begin
                        result_q <= is_avg ? avg_result : bus.rom_data;
                    end
                end
                WRITE: begin
                    if (bus.fb_ready) begin
                        write_ptr_q <= write_ptr_q + 15'd1;
                        x_out_q     <= x_next;
                        y_out_q     <= y_next;
                        k_q         <= '0;
                        sum_q       <= '0;
                        // The next pixel's first address goes out with the write,
                        // but never past the last row once the job is complete.
                        if (!wr_last) begin
                            rom_addr_q <= next_base;
                        end
                    end
                end
                default: begin
                end
            endcase
            if (bus.abort && (state_q != IDLE)) begin
                x_out_q     <= '0;
                y_out_q     <= '0;
                k_q         <= '0;
                write_ptr_q <= '0;
                sum_q       <= '0;
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FINISH);
    assign bus.err       = err_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.fb_we     = (state_q == WRITE);
    assign bus.fb_addr   = (state_q == WRITE) ? FB_BASE + {4'd0, write_ptr_q} : '0;
    assign bus.fb_data   = (state_q == WRITE) ? result_q : '0;
    assign state_dbg     = state_q;

endmodule

// File: doc/zoom_sequencer.md
# zoom_sequencer

Sequencing controller for the zoom/downscale datapath. It accepts a zoom command and walks the 160×120 source image in a single-port source RAM. For each output pixel it fetches the pixels needed (one for nearest, four for 2×2 average) and forms the output value with the same averaging rule as the datapath. It writes the result linearly into the frame buffer, which the VGA reader shares with it, so frame-buffer writes obey a ready backpressure handshake.

## Interface
- `IMG_WIDTH_IN`, 160: source width in pixels.
- `IMG_HEIGHT_IN`, 120: source height in pixels.
- `FB_BASE`, 0: frame-buffer address of output pixel 0.
- `clk` in 1: single clock; all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_zoom` in 3: 0 = ÷4 nearest (40×30), 1 = ÷2 average (80×60), 2 = copy (160×120), 3..7 illegal.
- `abort` in 1: cancel the current job.
- `rom_addr` out 15: source read address, registered.
- `rom_data` in 8: source pixel, valid the cycle after `rom_addr`.
- `fb_we` out 1: frame-buffer write request.
- `fb_addr` out 19: write address.
- `fb_data` out 8: write pixel.
- `fb_ready` in 1: write accepted when `fb_we & fb_ready`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a job completes.
- `err` out 1: one-cycle pulse when an illegal zoom is given.

## Operation
- States: IDLE, FETCH, WRITE, FINISH.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_zoom`, clear counters x_out/y_out/k.
  - Legal zoom: go to FETCH.
  - Illegal zoom: pulse `err` next cycle, stay in IDLE, no reads or writes.
- Geometry: shift s = 2 − zoom.
  - Output width = 160>>s, output height = 120>>s, size N = width × height.
  - Fetch origin: x_in = x_out<<s, y_in = y_out<<s.
- FETCH, nearest (zoom 0, 2): issue one read at `y_in*IMG_WIDTH_IN + x_in`, then capture `rom_data` as p0.
- FETCH, average (zoom 1): issue reads in order p0 = (x_in, y_in), p1 = (x_in+1, y_in), p2 = (x_in, y_in+1), p3 = (x_in+1, y_in+1), one per cycle.
  - Each `rom_data` is captured one cycle after its address.
  - Sum is 10 bits; result is 8 bits (see Configuration).
- WRITE: assert `fb_we` with `fb_addr = FB_BASE + write_ptr` and `fb_data = result`.
  - All three are held stable until `fb_ready`.
  - On acceptance, write_ptr++ and x_out++. When x_out reaches width−1 it wraps to 0 and y_out++.
  - If write_ptr == N−1 at acceptance, go to FINISH; otherwise go back to FETCH.
- FINISH: pulse `done` for one cycle, go to IDLE.
- Abort: when `abort`=1 in a non-IDLE state, the next state is IDLE.
  - No `done` pulse; counters are cleared.
  - A write accepted (`fb_we & fb_ready`) in the same cycle counts as written.
  - Abort is ignored in IDLE, and a `cmd_valid` in the same cycle is still accepted.
- Reset: asynchronous, at any time.
  - Returns to IDLE.
  - All outputs go to their reset values: `rom_addr`=0, `fb_we`=0, `fb_addr`=0, `fb_data`=0, `busy`=0, `done`=0, `err`=0, `cmd_ready`=1 after deassertion.

## Timing
- Command accepted at edge E. `busy` is high and `rom_addr` holds the first address from E+1.
- Nearest mode, `fb_ready`=1: 3 cycles per pixel (address, capture, write).
- Average mode, `fb_ready`=1: 6 cycles per pixel (4 addresses, last capture, write).
- Each cycle with `fb_ready`=0 during WRITE adds one cycle.
- `done` is asserted exactly 1 cycle after the final write is accepted.
- `busy` drops in the cycle after `done`.
- Job lengths at zero stall, from E to `done`:
  - zoom 0: 3600 + 1 cycles.
  - zoom 1: 28800 + 1 cycles.
  - zoom 2: 57600 + 1 cycles.
- No source read is ever more than 1 beyond the image edge. Maximum `rom_addr` is 19199.

## Configuration
- `ZOOM_ROUND_EN`:
  - Defined: average result = (sum + 2) >> 2, computed in 10 bits; the maximum sum 1020+2 does not overflow.
  - Undefined: average result = sum >> 2 (truncation, matching the datapath default).
- The macro affects only zoom 1.

## Test plan
- Zoom 1 with first block pixels 10, 20, 30, 42 (sum 102) -> first `fb_data` = 25 without the macro, 26 with `ZOOM_ROUND_EN`. First four `rom_addr` values = 0, 1, 160, 161.
- Zoom 0 with ROM[i] = i mod 256 -> 1200 writes. Write 1 reads address 4; write 40 reads address 640. `done` at cycle 3601 after acceptance.
- Zoom 2 with `fb_ready` low for 5 cycles on write 0 -> `fb_addr`/`fb_data` held stable. Total job length 57606 cycles, 19200 writes with addresses `FB_BASE`..`FB_BASE`+19199.
- `cmd_zoom`=5 -> `err` pulse 1 cycle, zero reads and writes, `cmd_ready` stays 1, `done` never asserted.
- `abort` in the same cycle a write is accepted on pixel 100 of zoom 1 -> 101 writes total, IDLE next cycle, no `done`. A new command is accepted immediately afterwards and restarts at `fb_addr` = `FB_BASE`.
- `reset_n` asserted mid-WRITE -> `fb_we`, `busy`, `done` go to 0 with no clock edge. After release, `cmd_ready`=1 and a fresh zoom 1 job completes correctly.
